// File: rtl/bus_slave_resp_mux_if.sv
// Bus bundle between the address decoder / slaves and the master for
// bus_slave_resp_mux. The mux connects through the "slave" modport; the
// "master" modport is the view of whoever drives the strobes and slave
// returns and consumes the registered response.
interface bus_slave_resp_mux_if #(
   parameter int N_SLAVES = 8,
   parameter int DATA_W   = 32
);
   logic                         m_as_;
   logic [N_SLAVES-1:0]          s_cs_;
   logic [N_SLAVES*DATA_W-1:0]   s_rd_data;
   logic [N_SLAVES-1:0]          s_rdy_;
   logic [DATA_W-1:0]            m_rd_data;
   logic                         m_rdy_;
   logic                         m_err;
   logic                         m_multi_cs;
   logic                         m_busy;

   modport slave (
      input  m_as_, s_cs_, s_rd_data, s_rdy_,
      output m_rd_data, m_rdy_, m_err, m_multi_cs, m_busy
   );

   modport master (
      output m_as_, s_cs_, s_rd_data, s_rdy_,
      input  m_rd_data, m_rdy_, m_err, m_multi_cs, m_busy
   );
endinterface

// File: rtl/bus_slave_resp_mux.sv
// Registered bus slave read-data/ready mux.
// Latches the lowest-index active chip select when the master strobes,
// waits for that slave's ready and returns a one-cycle registered response.
// Decode misses and multiple chip selects are flagged.
// Optional feature macro: BUS_TIMEOUT_EN builds a watchdog counter that
// ends a hung access with an error response after TMO_CYC WAIT cycles.
//
// state | meaning
// IDLE  | no access in flight, waiting for m_as_
// WAIT  | slave latched in sel_q, waiting for its ready (or timeout)
// RESP  | m_rdy_ low for exactly this cycle, then back to IDLE
module bus_slave_resp_mux #(
   parameter int N_SLAVES = 8,
   parameter int DATA_W   = 32,
   parameter int TMO_CYC  = 256
) (
   input  logic               clk,
   input  logic               reset_,
   bus_slave_resp_mux_if.slave bus
);
   localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rdy_q, rdy_d;
   logic              err_q, err_d;
   logic              multi_q, multi_d;
   logic              busy_q, busy_d;

   logic              cs_found;
   logic              cs_multi;
   logic [SEL_W-1:0]  cs_lowest;

`ifdef BUS_TIMEOUT_EN
   localparam int CNT_W = $clog2(TMO_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   logic [CNT_W-1:0] cnt_q, cnt_d;
`else
   // Timeout parameter is kept in the parameter list for drop-in
   // compatibility; without the watchdog it drives nothing.
   logic [31:0] unused_tmo;
   assign unused_tmo = TMO_CYC;
`endif

   // Fixed priority pick of the lowest active chip select, plus multi-select detect.
   always_comb begin
      cs_found  = 1'b0;
      cs_multi  = 1'b0;
      cs_lowest = '0;
      for (int i = 0; i < N_SLAVES; i++) begin
         if (!bus.s_cs_[i]) begin
            if (cs_found) begin
               cs_multi = 1'b1;
            end else begin
               cs_found  = 1'b1;
               cs_lowest = SEL_W'(i);
            end
         end
      end
   end

   // Next-state and response capture.
   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      rd_data_d = rd_data_q;
      err_d     = err_q;
      multi_d   = 1'b0;
`ifdef BUS_TIMEOUT_EN
      cnt_d     = cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (!bus.m_as_) begin
               if (cs_found) begin
                  sel_d   = cs_lowest;
                  multi_d = cs_multi;
                  state_d = ST_WAIT;
`ifdef BUS_TIMEOUT_EN
                  cnt_d   = '0;
`endif
               end else begin
                  rd_data_d = '0;
                  err_d     = 1'b1;
                  state_d   = ST_RESP;
               end
            end
         end
         ST_WAIT: begin
            // Ready is checked first so it wins over a coincident timeout.
            if (!bus.s_rdy_[sel_q]) begin
               rd_data_d = bus.s_rd_data[sel_q*DATA_W +: DATA_W];
               err_d     = 1'b0;
               state_d   = ST_RESP;
            end else begin
`ifdef BUS_TIMEOUT_EN
               if (cnt_q == CNT_LAST) begin
                  rd_data_d = '0;
                  err_d     = 1'b1;
                  state_d   = ST_RESP;
               end else if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + 1'b1;
               end
`endif
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Strobes are derived from the next state so they are pure flop outputs.
      rdy_d  = (state_d != ST_RESP);
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state_q   <= ST_IDLE;
         sel_q     <= '0;
         rd_data_q <= '0;
         rdy_q     <= 1'b1;
         err_q     <= 1'b0;
         multi_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         rd_data_q <= rd_data_d;
         rdy_q     <= rdy_d;
         err_q     <= err_d;
         multi_q   <= multi_d;
         busy_q    <= busy_d;
      end
   end

`ifdef BUS_TIMEOUT_EN
   // Watchdog counter register.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   assign bus.m_rd_data  = rd_data_q;
   assign bus.m_rdy_     = rdy_q;
   assign bus.m_err      = err_q;
   assign bus.m_multi_cs = multi_q;
   assign bus.m_busy     = busy_q;

endmodule
